uart_avl_master_bridge: RTL and testbench
=========================================

Name: uart_avl_master_bridge

Overview:
- UART-to-Avalon-MM command bridge. It receives 8N1 command frames on a UART RX line and issues single Avalon-MM read or write transfers as bus initiator.
- It returns a status byte, or status plus read data, on UART TX.
- It is the initiator counterpart of the Avalon-slave UART interface, so a host PC or a UART agent can drive registers on an Avalon bus.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUDRATE, 9600, UART bit rate; bit period BITCYC = CLK_FREQ/BAUDRATE cycles (integer division).
- ADDR_W, 14, Avalon address width; the 8-bit command address is zero-extended.
- RD_TIMEOUT, 1024, cycles to wait for readdatavalid before NAK.
- GAP_TIMEOUT, 20, idle bit periods between command bytes before the parser aborts.

Ports:
- avl_clk_i  in  1  system clock.
- avl_reset_i  in  1  asynchronous reset, active low.
- rx_i  in  1  UART receive line, idle high, asynchronous.
- tx_o  out  1  UART transmit line, idle high.
- avl_address_o  out  ADDR_W  word address.
- avl_byteenable_o  out  4  always 4'hF during a transfer, else 0.
- avl_write_o  out  1  write request.
- avl_writedata_o  out  32  write data.
- avl_read_o  out  1  read request.
- avl_readdatavalid_i  in  1  read data valid.
- avl_readdata_i  in  32  read data.
- avl_waitrequest_i  in  1  slave stall.
- busy_o  out  1  high from first command byte until last response bit sent.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx_o=1.
  - All Avalon outputs 0.
  - busy_o=0.
  - Every FSM in IDLE.
- RX path:
  - rx_i passes through a 2-flop synchroniser; its value is 1 at reset.
  - A falling edge in IDLE starts a frame. The start bit is re-checked at BITCYC/2; if rx is high, the edge is a glitch and RX returns to IDLE.
  - 8 data bits are sampled LSB first at mid-bit, each BITCYC apart.
  - The stop bit is sampled at mid-bit. Stop=0 is a framing error: the byte is discarded, the parser aborts and returns to P_OP, and no response is sent.
- Command protocol, one byte each:
  - Write: 0x57, ADDR, D0, D1, D2, D3 (data LSB byte first).
  - Read: 0x52, ADDR.
  - Any other opcode is silently discarded and the parser stays in P_OP.
- Parser states: P_OP -> P_ADDR -> (write: P_D0..P_D3) -> EXEC.
  - A gap of more than GAP_TIMEOUT*BITCYC cycles between bytes in any state except P_OP returns the parser to P_OP with no response.
- Avalon master FSM: IDLE, WR, RD, RDWAIT, RESP.
  - WR: avl_write_o, address, data and byteenable are held stable while avl_waitrequest_i=1. The transfer completes on the first rising edge with waitrequest=0. Response is 0x06.
  - RD: avl_read_o is held until waitrequest=0, then deasserted next cycle. RDWAIT captures readdata on the first readdatavalid. Response is 0x06 followed by D0..D3, LSB byte first.
  - If readdatavalid also arrives in the accept cycle, it is accepted.
  - If RD_TIMEOUT cycles pass in RDWAIT with no readdatavalid, response is 0x15 (NAK) only.
  - Waitrequest itself has no timeout.
- TX path:
  - Each byte is sent as 8N1: start 0, 8 data bits LSB first, stop 1, each bit exactly BITCYC cycles.
  - Bytes are sent back-to-back with no extra idle.
  - The first start bit begins at most 2 cycles after the response is ready.
- Concurrency:
  - RX stays active while a command executes.
  - Bytes received while the master FSM is not IDLE are dropped and do not advance the parser.
  - busy_o falls after the final stop bit completes.
- Reset mid-operation:
  - Avalon requests drop immediately (asynchronous).
  - tx_o goes high immediately; a partial TX frame is truncated.

Test Plan:
1. Write, no stall: UART bytes 57 10 EF BE AD DE -> one Avalon write, address 0x010, writedata 0xDEADBEEF, byteenable F, write_o high 1 cycle; TX returns 0x06.
2. Read with stall and latency: bytes 52 22; slave holds waitrequest 3 cycles and returns 0x12345678 5 cycles after accept -> read_o high exactly 4 cycles with stable address 0x022; TX sends 06 78 56 34 12.
3. Read timeout: bytes 52 01; readdatavalid never asserted -> read_o accepted; after 1024 cycles TX sends only 0x15; bridge returns to IDLE with busy_o=0.
4. Errors: stop bit forced 0 on the ADDR byte, then opcode 0x41 -> no Avalon activity, no TX; a following valid read 52 00 executes normally.
5. Gap timeout: bytes 57 10 AA, then idle 25 bit periods, then 52 00 -> the partial write is aborted; only the read is executed and answered.
6. Reset mid-response: assert avl_reset_i low during the 2nd TX byte -> tx_o=1, Avalon outputs 0, busy_o=0 immediately; after release, the next command is handled normally.

Source files
------------

// File: rtl/uart_avl_master_bridge.sv
// UART 8N1 command receiver that issues single Avalon-MM read/write transfers and replies on UART TX.
// Latency: transfer starts 1 cycle after the last command byte's stop sample; reply starts 1 cycle after completion.
// Backpressure: waitrequest stalls the transfer indefinitely; bytes arriving while a transfer or reply is in flight are dropped.
module uart_avl_master_bridge #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUDRATE    = 9600,
    parameter int ADDR_W      = 14,
    parameter int RD_TIMEOUT  = 1024,
    parameter int GAP_TIMEOUT = 20
) (
    input  logic              avl_clk_i,
    input  logic              avl_reset_i,
    input  logic              rx_i,
    output logic              tx_o,
    output logic [ADDR_W-1:0] avl_address_o,
    output logic [3:0]        avl_byteenable_o,
    output logic              avl_write_o,
    output logic [31:0]       avl_writedata_o,
    output logic              avl_read_o,
    input  logic              avl_readdatavalid_i,
    input  logic [31:0]       avl_readdata_i,
    input  logic              avl_waitrequest_i,
    output logic              busy_o
);
    localparam int BITCYC  = CLK_FREQ / BAUDRATE;
    localparam int CW      = $clog2(BITCYC + 1);
    localparam int GAP_CYC = GAP_TIMEOUT * BITCYC;
    localparam int GW      = $clog2(GAP_CYC + 1);
    localparam int TW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BITCYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BITCYC / 2 - 1);
    localparam logic [GW-1:0] GAP_END   = GW'(GAP_CYC);
    localparam logic [TW-1:0] RD_LAST   = TW'(RD_TIMEOUT - 1);
    localparam logic [7:0]    OP_WR = 8'h57;
    localparam logic [7:0]    OP_RD = 8'h52;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [2:0] {P_OP, P_ADDR, P_D0, P_D1, P_D2, P_D3} p_state_t;
    typedef enum logic [2:0] {M_IDLE, M_WR, M_RD, M_RDWAIT, M_RESP} m_state_t;

    logic rst_q1, rst_n;
    logic rx_s1, rx_s2, rx_d;
    r_state_t r_state, r_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic          rx_vld, rx_ferr, byte_ok, gap_to;
    p_state_t      p_state, p_next;
    m_state_t      m_state, m_next;
    logic          cmd_wr, go_wr, go_rd, resp_load, rd_cap, tx_load;
    logic [7:0]    resp_byte0;
    logic [2:0]    resp_n, resp_left;
    logic [39:0]   resp_buf;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] rd_tmr;
    logic          tx_act;
    logic [9:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;

    // Reset asserts asynchronously everywhere but releases in step with the clock.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) {rst_q1, rst_n} <= 2'b00;
        else              {rst_q1, rst_n} <= {1'b1, rst_q1};
    end

    always_ff @(posedge avl_clk_i or negedge rst_n) begin
        if (!rst_n) {rx_s1, rx_s2, rx_d} <= 3'b111;
        else        {rx_s1, rx_s2, rx_d} <= {rx_i, rx_s1, rx_s2};
    end

    always_comb begin
        r_next  = r_state;
        rx_vld  = 1'b0;
        rx_ferr = 1'b0;
        case (r_state)
            R_IDLE:  if (rx_d && !rx_s2) r_next = R_START;
            R_START: if (r_cnt == HALF_LAST) r_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (r_cnt == BIT_LAST && r_bit == 3'd7) r_next = R_STOP;
            R_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    r_next  = R_IDLE;
                    rx_vld  = rx_s2;
                    rx_ferr = !rx_s2;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge avl_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE || (r_state == R_START && r_cnt == HALF_LAST) || r_cnt == BIT_LAST)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == R_IDLE)
                r_bit <= '0;
            else if (r_state == R_DATA && r_cnt == BIT_LAST) begin
                r_sh  <= {rx_s2, r_sh[7:1]};
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    assign byte_ok = rx_vld && (m_state == M_IDLE);
    assign gap_to  = (gap_cnt == GAP_END);
    assign tx_load = (m_state == M_RESP) && (resp_left != 3'd0) &&
                     (!tx_act || (tx_cnt == BIT_LAST && tx_bits == 4'd9));

    always_comb begin
        p_next     = p_state;
        m_next     = m_state;
        go_wr      = 1'b0;
        go_rd      = 1'b0;
        resp_load  = 1'b0;
        resp_byte0 = 8'h06;
        resp_n     = 3'd1;
        rd_cap     = 1'b0;
        if (rx_ferr || (gap_to && p_state != P_OP)) begin
            p_next = P_OP;
        end else if (byte_ok) begin
            case (p_state)
                P_OP:   if (r_sh == OP_WR || r_sh == OP_RD) p_next = P_ADDR;
                P_ADDR: begin
                    p_next = cmd_wr ? P_D0 : P_OP;
                    go_rd  = !cmd_wr;
                end
                P_D0:   p_next = P_D1;
                P_D1:   p_next = P_D2;
                P_D2:   p_next = P_D3;
                P_D3: begin
                    p_next = P_OP;
                    go_wr  = 1'b1;
                end
                default: p_next = P_OP;
            endcase
        end
        case (m_state)
            M_IDLE: begin
                if (go_wr)      m_next = M_WR;
                else if (go_rd) m_next = M_RD;
            end
            M_WR: begin
                if (!avl_waitrequest_i) begin
                    m_next    = M_RESP;
                    resp_load = 1'b1;
                end
            end
            M_RD, M_RDWAIT: begin
                // Data arriving in the accept cycle itself is taken straight away.
                if ((m_state == M_RDWAIT || !avl_waitrequest_i) && avl_readdatavalid_i) begin
                    m_next    = M_RESP;
                    resp_load = 1'b1;
                    resp_n    = 3'd5;
                    rd_cap    = 1'b1;
                end else if (m_state == M_RD && !avl_waitrequest_i) begin
                    m_next = M_RDWAIT;
                end else if (m_state == M_RDWAIT && rd_tmr == RD_LAST) begin
                    m_next     = M_RESP;
                    resp_load  = 1'b1;
                    resp_byte0 = 8'h15;
                end
            end
            M_RESP:  if (!tx_act && resp_left == 3'd0) m_next = M_IDLE;
            default: m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge avl_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            p_state         <= P_OP;
            m_state         <= M_IDLE;
            cmd_wr          <= 1'b0;
            avl_address_o   <= '0;
            avl_writedata_o <= '0;
            gap_cnt         <= '0;
            rd_tmr          <= '0;
            resp_buf        <= '0;
            resp_left       <= '0;
            tx_act          <= 1'b0;
            tx_sh           <= '1;
            tx_cnt          <= '0;
            tx_bits         <= '0;
        end else begin
            p_state <= p_next;
            m_state <= m_next;
            if (r_state != R_IDLE || p_state == P_OP) gap_cnt <= '0;
            else if (!gap_to)                         gap_cnt <= gap_cnt + 1'b1;
            if (byte_ok) begin
                case (p_state)
                    P_OP:                   cmd_wr          <= (r_sh == OP_WR);
                    P_ADDR:                 avl_address_o   <= ADDR_W'(r_sh);
                    P_D0, P_D1, P_D2, P_D3: avl_writedata_o <= {r_sh, avl_writedata_o[31:8]};
                    default: ;
                endcase
            end
            rd_tmr <= (m_state == M_RDWAIT) ? rd_tmr + 1'b1 : '0;
            if (resp_load) begin
                resp_buf  <= {(rd_cap ? avl_readdata_i : 32'h0), resp_byte0};
                resp_left <= resp_n;
            end
            if (tx_load) begin
                tx_sh     <= {1'b1, resp_buf[7:0], 1'b0};
                resp_buf  <= {8'h00, resp_buf[39:8]};
                resp_left <= resp_left - 1'b1;
                tx_act    <= 1'b1;
                tx_cnt    <= '0;
                tx_bits   <= '0;
            end else if (tx_act) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_bits == 4'd9) begin
                        tx_act <= 1'b0;
                    end else begin
                        tx_sh   <= {1'b1, tx_sh[9:1]};
                        tx_bits <= tx_bits + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    assign tx_o             = tx_act ? tx_sh[0] : 1'b1;
    assign avl_write_o      = (m_state == M_WR);
    assign avl_read_o       = (m_state == M_RD);
    assign avl_byteenable_o = (avl_write_o || avl_read_o) ? 4'hF : 4'h0;
    assign busy_o           = (p_state != P_OP) || (m_state != M_IDLE);
endmodule

// File: tb/tb_uart_avl_master_bridge.sv
// Bench for uart_avl_master_bridge: UART driver/decoder, Avalon slave, vector table and a command-level model.
module tb_uart_avl_master_bridge;
    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUDRATE   = 62_500;
    localparam int BITCYC     = CLK_FREQ / BAUDRATE;
    localparam int ADDR_W     = 14;
    localparam int RD_TIMEOUT = 1024;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {logic wr; logic [ADDR_W-1:0] addr; logic [31:0] data;} xact_t;
    typedef struct {
        bit wr; logic [7:0] addr; logic [31:0] data;
        int stall; int lat; bit rdv;
        int exp_n; logic [39:0] exp_resp; int exp_hi; int dmin; int dmax;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, tx;
    logic [ADDR_W-1:0] addr;
    logic [3:0]  be;
    logic        wr, rd, busy;
    logic        rdv = 1'b0, wait_r = 1'b0;
    logic [31:0] wdata, rdata = 32'h0;

    int checks = 0, failures = 0, cyc = 0;
    int stall_cfg = 0, lat_cfg = 0;
    bit rdv_en = 1'b1;
    logic [31:0] rd_data_cfg = 32'h0;
    int rd_hi, wr_hi, addr_bad, be_bad, acc_cyc;
    xact_t xq[$], exp_x[$];
    logic [7:0] tx_q[$], exp_r[$];
    int tx_t[$];
    vec_t vt[5];

    uart_avl_master_bridge #(
        .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .ADDR_W(ADDR_W),
        .RD_TIMEOUT(RD_TIMEOUT), .GAP_TIMEOUT(20)
    ) dut (
        .avl_clk_i(clk), .avl_reset_i(rst_n), .rx_i(rx), .tx_o(tx),
        .avl_address_o(addr), .avl_byteenable_o(be), .avl_write_o(wr),
        .avl_writedata_o(wdata), .avl_read_o(rd), .avl_readdatavalid_i(rdv),
        .avl_readdata_i(rdata), .avl_waitrequest_i(wait_r), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Avalon slave: programmable waitrequest stall and read latency.
    initial begin : slave
        int stall_left, rd_pend;
        bit in_xfer;
        logic [ADDR_W-1:0] xaddr;
        logic [31:0] xdata;
        in_xfer = 0; rd_pend = 0; stall_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_xfer = 0; rd_pend = 0; wait_r = 1'b0; rdv = 1'b0;
            end else begin
                rdv = 1'b0;
                if (rd_pend > 0) begin
                    rd_pend--;
                    if (rd_pend == 0) begin rdv = 1'b1; rdata = rd_data_cfg; end
                end
                if (be !== ((wr || rd) ? 4'hF : 4'h0) || (wr && rd)) be_bad++;
                if (wr || rd) begin
                    if (!in_xfer) begin
                        in_xfer = 1; stall_left = stall_cfg; xaddr = addr; xdata = wdata;
                    end else if (addr !== xaddr || (wr && wdata !== xdata)) addr_bad++;
                    if (rd) rd_hi++; else wr_hi++;
                    if (stall_left > 0) begin
                        wait_r = 1'b1; stall_left--;
                    end else begin
                        wait_r = 1'b0; in_xfer = 0; acc_cyc = cyc;
                        xq.push_back('{wr: wr, addr: addr, data: (wr ? wdata : 32'h0)});
                        if (rd && rdv_en) begin
                            if (lat_cfg == 0) begin rdv = 1'b1; rdata = rd_data_cfg; end
                            else rd_pend = lat_cfg;
                        end
                    end
                end else begin
                    wait_r = 1'b0; in_xfer = 0;
                end
            end
        end
    end

    // UART TX decoder: records each byte with the cycle its start bit began.
    initial begin : tx_mon
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                t = cyc;
                repeat (BITCYC / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BITCYC) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (BITCYC) @(negedge clk);
                    if (tx === 1'b1) begin tx_q.push_back(b); tx_t.push_back(t); end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        @(negedge clk) rx = 1'b0;
        repeat (BITCYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITCYC) @(negedge clk);
        end
        rx = stop;
        repeat (BITCYC) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (BITCYC) @(negedge clk);
    endtask

    task automatic clear_obs();
        xq.delete(); tx_q.delete(); tx_t.delete();
        rd_hi = 0; wr_hi = 0; addr_bad = 0; be_bad = 0; acc_cyc = 0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 4000) begin @(negedge clk); k++; end
        chk_rng({nm, "_idle_wait"}, k, 0, 3999);
        repeat (BITCYC) @(negedge clk);
    endtask

    // Command-level reference: walks the byte stream by protocol rules.
    task automatic model(input byte_q_t bq);
        int i = 0;
        exp_x.delete(); exp_r.delete();
        while (i < bq.size()) begin
            if (bq[i] == 8'h57 && i + 5 < bq.size()) begin
                exp_x.push_back('{wr: 1'b1, addr: ADDR_W'(bq[i+1]),
                                  data: {bq[i+5], bq[i+4], bq[i+3], bq[i+2]}});
                exp_r.push_back(8'h06);
                i += 6;
            end else if (bq[i] == 8'h52 && i + 1 < bq.size()) begin
                exp_x.push_back('{wr: 1'b0, addr: ADDR_W'(bq[i+1]), data: 32'h0});
                if (rdv_en) begin
                    exp_r.push_back(8'h06);
                    for (int k = 0; k < 4; k++) exp_r.push_back(rd_data_cfg[8*k +: 8]);
                end else begin
                    exp_r.push_back(8'h15);
                end
                i += 2;
            end else begin
                i++;
            end
        end
    endtask

    task automatic cmp_model(input string nm);
        chk({nm, "_xn"}, xq.size(), exp_x.size());
        for (int i = 0; i < xq.size() && i < exp_x.size(); i++) chk({nm, "_x"}, xq[i], exp_x[i]);
        chk({nm, "_rn"}, tx_q.size(), exp_r.size());
        for (int i = 0; i < tx_q.size() && i < exp_r.size(); i++) chk({nm, "_r"}, tx_q[i], exp_r[i]);
        chk({nm, "_hi"}, rd_hi + wr_hi, (stall_cfg + 1) * exp_x.size());
        chk({nm, "_stable"}, addr_bad + be_bad, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        byte_q_t bq;
        clear_obs();
        stall_cfg = v.stall; lat_cfg = v.lat; rdv_en = v.rdv; rd_data_cfg = v.data;
        bq.push_back(v.wr ? 8'h57 : 8'h52);
        bq.push_back(v.addr);
        if (v.wr) for (int i = 0; i < 4; i++) bq.push_back(v.data[8*i +: 8]);
        send_byte(bq[0], 1'b1);
        chk({nm, "_busy_mid"}, busy, 1);
        for (int i = 1; i < bq.size(); i++) send_byte(bq[i], 1'b1);
        wait_idle(nm);
        chk({nm, "_xn"}, xq.size(), 1);
        if (xq.size() > 0) begin
            chk({nm, "_xwr"}, xq[0].wr, v.wr);
            chk({nm, "_xaddr"}, xq[0].addr, {6'h0, v.addr});
            chk({nm, "_xdata"}, xq[0].data, v.wr ? v.data : 32'h0);
        end
        chk({nm, "_rn"}, tx_q.size(), v.exp_n);
        for (int i = 0; i < tx_q.size() && i < v.exp_n; i++) chk({nm, "_rbyte"}, tx_q[i], v.exp_resp[8*i +: 8]);
        if (tx_t.size() > 0) chk_rng({nm, "_dly"}, tx_t[0] - acc_cyc, v.dmin, v.dmax);
        for (int i = 1; i < tx_t.size(); i++) chk({nm, "_space"}, tx_t[i] - tx_t[i-1], 10 * BITCYC);
        chk({nm, "_hi"}, v.wr ? wr_hi : rd_hi, v.exp_hi);
        chk({nm, "_stable"}, addr_bad + be_bad, 0);
        chk({nm, "_busy_end"}, busy, 0);
    endtask

    initial begin
        byte_q_t bq;
        int k;
        vt[0] = '{wr: 1, addr: 8'h10, data: 32'hDEADBEEF, stall: 0, lat: 0, rdv: 1,
                  exp_n: 1, exp_resp: 40'h06, exp_hi: 1, dmin: 1, dmax: 3};
        vt[1] = '{wr: 0, addr: 8'h22, data: 32'h12345678, stall: 3, lat: 5, rdv: 1,
                  exp_n: 5, exp_resp: 40'h12345678_06, exp_hi: 4, dmin: 6, dmax: 9};
        vt[2] = '{wr: 0, addr: 8'h01, data: 32'h0, stall: 0, lat: 0, rdv: 0,
                  exp_n: 1, exp_resp: 40'h15, exp_hi: 1, dmin: RD_TIMEOUT + 1, dmax: RD_TIMEOUT + 4};
        vt[3] = '{wr: 1, addr: 8'hFF, data: 32'h00000001, stall: 2, lat: 0, rdv: 1,
                  exp_n: 1, exp_resp: 40'h06, exp_hi: 3, dmin: 1, dmax: 3};
        vt[4] = '{wr: 0, addr: 8'h80, data: 32'hA5A55A5A, stall: 1, lat: 0, rdv: 1,
                  exp_n: 5, exp_resp: 40'hA5A55A5A_06, exp_hi: 2, dmin: 1, dmax: 3};

        repeat (5) @(negedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_rw", {wr, rd}, 0);
        chk("reset_be", be, 0);
        chk("reset_busy", busy, 0);
        chk("reset_addr", addr, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Framing error on the address byte, then an unknown opcode.
        clear_obs();
        stall_cfg = 0; lat_cfg = 2; rdv_en = 1; rd_data_cfg = 32'hC0FFEE11;
        send_byte(8'h52, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h41, 1'b1);
        repeat (4 * BITCYC) @(negedge clk);
        chk("err_no_xact", xq.size(), 0);
        chk("err_no_tx", tx_q.size(), 0);
        chk("err_busy", busy, 0);
        bq = '{8'h52, 8'h00};
        model(bq);
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        wait_idle("err_follow");
        cmp_model("err_follow");

        // Partial write abandoned by an inter-byte gap.
        clear_obs();
        rd_data_cfg = 32'hCAFEF00D;
        send_byte(8'h57, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (25 * BITCYC) @(negedge clk);
        chk("gap_busy", busy, 0);
        bq = '{8'h52, 8'h00};
        model(bq);
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        wait_idle("gap");
        cmp_model("gap");

        // Reset during the second response byte.
        clear_obs();
        lat_cfg = 1; rd_data_cfg = 32'h0BADF000;
        send_byte(8'h52, 1'b1);
        send_byte(8'h33, 1'b1);
        k = 0;
        while (tx_q.size() < 1 && k < 4000) begin @(negedge clk); k++; end
        chk_rng("rst_first_byte_wait", k, 0, 3999);
        repeat (2 * BITCYC) @(negedge clk);
        chk("rst_pre_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_rw", {wr, rd}, 0);
        chk("rst_be", be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BITCYC) @(negedge clk);
        run_vec(vt[3], "post_rst");

        // Randomized commands, optionally preceded by a junk opcode.
        for (int it = 0; it < 6; it++) begin
            logic [7:0] junk;
            logic [31:0] d;
            clear_obs();
            stall_cfg = $urandom_range(0, 3);
            lat_cfg = $urandom_range(0, 6);
            rdv_en = ($urandom_range(0, 7) != 0);
            rd_data_cfg = $urandom;
            bq.delete();
            if ($urandom_range(0, 1) == 1) begin
                junk = 8'($urandom);
                if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
                bq.push_back(junk);
            end
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                bq.push_back(8'h57);
                bq.push_back(8'($urandom));
                for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
            end else begin
                bq.push_back(8'h52);
                bq.push_back(8'($urandom));
            end
            model(bq);
            foreach (bq[i]) send_byte(bq[i], 1'b1);
            wait_idle($sformatf("rnd%0d", it));
            cmp_model($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
